fence_flush_sequencer: RTL
==========================

// Module: fence_flush_sequencer
// PURPOSE
//  Sequences the multi-cycle side effects of fence-class instructions retiring on commit port 0.
//  Covers FENCE, FENCE.I, SFENCE.VMA and the external D$ flush request.
//  Order: store-buffer drain -> D$ flush -> I$ or TLB flush -> pipeline flush.
//  Sits beside the commit stage. Its one-cycle done pulse is the commit acknowledge for port 0.
//  Its flush pulses feed the controller and the caches.
// PARAMETERS
//  DRAIN_TIMEOUT  255  max cycles in DRAIN before drain_timeout_o asserts; counter width $clog2(DRAIN_TIMEOUT+1)
// PORTS
//  clk_i               in   1  clock; all state changes on its rising edge
//  rst_i               in   1  reset; synchronous, active-high
//  req_valid_i         in   1  fence-class instruction at commit port 0, valid, no exception
//  req_type_i          in   2  0=FENCE 1=FENCE_I 2=SFENCE_VMA 3=DCACHE_FLUSH; sampled in IDLE only
//  halt_i              in   1  core halt request
//  no_st_pending_i     in   1  store buffer empty
//  dcache_flush_o      out  1  D$ flush request; level, held until acknowledged
//  dcache_flush_ack_i  in   1  D$ flush complete; single-cycle
//  icache_flush_o      out  1  I$ flush; 1-cycle pulse
//  tlb_flush_o         out  1  TLB flush; 1-cycle pulse
//  flush_pipeline_o    out  1  pipeline flush; 1-cycle pulse
//  done_o              out  1  commit ack for port 0; 1-cycle pulse
//  busy_o              out  1  state != IDLE
//  drain_timeout_o     out  1  drain watchdog expired; level
//  state_o             out  3  current state encoding (debug)
// BEHAVIOUR
//  Reset
//   - State IDLE; latched type 0; drain counter 0.
//   - All outputs 0.
//   - rst_i mid-sequence returns to IDLE next edge, with no trailing pulses.
//  States: IDLE=0 DRAIN=1 DFLUSH=2 IFLUSH=3 TLBFL=4 DONE=5; 6 and 7 recover to IDLE
//  IDLE
//   - req_valid_i && !halt_i -> DRAIN; latch req_type_i.
//   - Otherwise stay.
//  DRAIN
//   - Counter increments each cycle, saturating at DRAIN_TIMEOUT.
//   - !req_valid_i or halt_i -> IDLE (abort; no side effects issued yet).
//   - Else no_st_pending_i: type 2 -> TLBFL; types 0, 1, 3 -> DFLUSH.
//   - Abort has priority over no_st_pending_i in the same cycle.
//  DFLUSH
//   - dcache_flush_o=1 every cycle in this state.
//   - On dcache_flush_ack_i: type 1 -> IFLUSH; else -> DONE.
//   - halt_i and req_valid_i are ignored here; an issued flush always completes.
//  IFLUSH: icache_flush_o=1 for 1 cycle -> DONE
//  TLBFL:  tlb_flush_o=1 for 1 cycle -> DONE
//  DONE
//   - flush_pipeline_o=1 and done_o=1 for 1 cycle -> IDLE.
//   - A new request is accepted in IDLE the following cycle at the earliest.
//  Watchdog
//   - drain_timeout_o = (state==DRAIN) && counter==DRAIN_TIMEOUT.
//   - Counter clears on entry to DRAIN and in every other state.
//   - Timeout only flags; it does not abort the sequence.
//  Latency, request-valid cycle to done_o (stores already drained)
//   - Type 2: 3 cycles.
//   - Types 0 and 3: 3 + ack delay, where ack delay counts cycles from the first DFLUSH cycle.
//   - Type 1: 4 + ack delay.
//  Invariants
//   - Pulse outputs are mutually exclusive.
//   - done_o never asserts without flush_pipeline_o.
//   - req_type_i changes after IDLE have no effect.
// TESTING
//  - Type 2, no_st_pending_i=1 from cycle 0, req at cycle 0 -> tlb_flush_o @2, done_o and flush_pipeline_o @3, dcache_flush_o never 1.
//  - Type 1, ack 4 cycles after dcache_flush_o rises -> dcache_flush_o high exactly cycles 2..6, icache_flush_o @7, done_o @8.
//  - Type 0, no_st_pending_i=0 for 300 cycles, DRAIN_TIMEOUT=255 -> drain_timeout_o high from DRAIN cycle 255; completes normally after drain.
//  - Type 3 in DRAIN, then halt_i=1 -> IDLE next cycle, no pulses; halt_i=1 in DFLUSH -> flush still completes with done_o.
//  - rst_i=1 while in DFLUSH -> all outputs 0 and state_o=0 next cycle; a later ack is ignored.
//  - Back-to-back requests, req_valid_i held high -> second sequence enters DRAIN the cycle after IDLE; no overlapping pulses.

Source files
------------

// File: rtl/fence_flush_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fence_flush_sequencer_if
// Description : Bundles the commit-side request, store-buffer status, D$
//               flush handshake and flush/ack outputs of the fence flush
//               sequencer.
//               slave  - seen by the sequencer (requests in, flushes out)
//               master - seen by the commit stage / caches driving it
// Signals     : req_valid_i, req_type_i[1:0], halt_i, no_st_pending_i,
//               dcache_flush_ack_i            (toward sequencer)
//               dcache_flush_o, icache_flush_o, tlb_flush_o,
//               flush_pipeline_o, done_o, busy_o, drain_timeout_o,
//               state_o[2:0]                  (from sequencer)
// Revision    : 1.0 - initial release
// ============================================================================
interface fence_flush_sequencer_if;
  logic       req_valid_i;
  logic [1:0] req_type_i;
  logic       halt_i;
  logic       no_st_pending_i;
  logic       dcache_flush_ack_i;
  logic       dcache_flush_o;
  logic       icache_flush_o;
  logic       tlb_flush_o;
  logic       flush_pipeline_o;
  logic       done_o;
  logic       busy_o;
  logic       drain_timeout_o;
  logic [2:0] state_o;

  modport slave (
    input  req_valid_i, req_type_i, halt_i, no_st_pending_i, dcache_flush_ack_i,
    output dcache_flush_o, icache_flush_o, tlb_flush_o, flush_pipeline_o,
           done_o, busy_o, drain_timeout_o, state_o
  );

  modport master (
    output req_valid_i, req_type_i, halt_i, no_st_pending_i, dcache_flush_ack_i,
    input  dcache_flush_o, icache_flush_o, tlb_flush_o, flush_pipeline_o,
           done_o, busy_o, drain_timeout_o, state_o
  );
endinterface
`default_nettype wire

// File: rtl/fence_flush_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fence_flush_sequencer
// Description : Sequences the side effects of fence-class instructions
//               retiring on commit port 0 (FENCE, FENCE.I, SFENCE.VMA and
//               external D$ flush): store-buffer drain -> D$ flush ->
//               I$ or TLB flush -> pipeline flush + commit acknowledge.
// Ports       : clk_i  - clock, rising edge
//               rst_i  - synchronous active-high reset
//               bus    - fence_flush_sequencer_if.slave (request, drain
//                        status, D$ handshake, flush pulses, status/debug)
// Parameters  : DRAIN_TIMEOUT - drain cycles before drain_timeout_o asserts
//                               (must be >= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module fence_flush_sequencer #(
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  fence_flush_sequencer_if.slave  bus
);

  localparam int                 c_CNT_W   = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DRAIN_TIMEOUT);

  localparam logic [1:0] c_TYPE_FENCE_I    = 2'd1;
  localparam logic [1:0] c_TYPE_SFENCE_VMA = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_DFLUSH = 3'd2,
    S_IFLUSH = 3'd3,
    S_TLBFL  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             r_state;
  logic [1:0]         r_type;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_dflush;
  logic               r_iflush;
  logic               r_tlb;
  logic               r_flpipe;
  logic               r_done;
  logic               r_timeout;

  logic [c_CNT_W-1:0] w_cnt_inc;

  // Saturating drain counter increment.
  assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // Outputs are registered alongside the state: each branch sets the output
  // registers for the state it is moving into, so every output is a flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_type    <= 2'd0;
      r_cnt     <= '0;
      r_dflush  <= 1'b0;
      r_iflush  <= 1'b0;
      r_tlb     <= 1'b0;
      r_flpipe  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_dflush  <= 1'b0;
      r_iflush  <= 1'b0;
      r_tlb     <= 1'b0;
      r_flpipe  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i && !bus.halt_i) begin
            r_state <= S_DRAIN;
            r_type  <= bus.req_type_i;
          end
        end
        S_DRAIN: begin
          // Abort wins over drain completion: nothing has been issued yet.
          if (!bus.req_valid_i || bus.halt_i) begin
            r_state <= S_IDLE;
          end else if (bus.no_st_pending_i) begin
            if (r_type == c_TYPE_SFENCE_VMA) begin
              r_state <= S_TLBFL;
              r_tlb   <= 1'b1;
            end else begin
              r_state  <= S_DFLUSH;
              r_dflush <= 1'b1;
            end
          end else begin
            r_cnt     <= w_cnt_inc;
            r_timeout <= (w_cnt_inc == c_CNT_MAX);
          end
        end
        S_DFLUSH: begin
          // Once issued the D$ flush always runs to completion.
          if (bus.dcache_flush_ack_i) begin
            if (r_type == c_TYPE_FENCE_I) begin
              r_state  <= S_IFLUSH;
              r_iflush <= 1'b1;
            end else begin
              r_state  <= S_DONE;
              r_flpipe <= 1'b1;
              r_done   <= 1'b1;
            end
          end else begin
            r_dflush <= 1'b1;
          end
        end
        S_IFLUSH, S_TLBFL: begin
          r_state  <= S_DONE;
          r_flpipe <= 1'b1;
          r_done   <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dcache_flush_o   = r_dflush;
  assign bus.icache_flush_o   = r_iflush;
  assign bus.tlb_flush_o      = r_tlb;
  assign bus.flush_pipeline_o = r_flpipe;
  assign bus.done_o           = r_done;
  assign bus.drain_timeout_o  = r_timeout;
  assign bus.busy_o           = (r_state != S_IDLE);
  assign bus.state_o          = r_state;

endmodule
`default_nettype wire
